axi_burst_write_port: RTL and testbench

Parametrised data-cache write-back port that turns one line-eviction request plus a stream of line data beats into a single AXI4 INCR write burst. It adds three things over the single-beat write port: configurable data width, configurable burst length and B-channel response tracking. It sits between the dcache write queue and the AXI interconnect. The port accepts exactly one line, issues AW and W for it, and waits for B before it accepts the next line.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/w_beat_buffer.sv | 75 +++++++
 rtl/axi_burst_write_port.sv | 195 +++++++++++++++++++
 tb/tb_axi_burst_write_port.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the dcache AXI write-back ports: the port state
// encoding, AXI burst/response constants and a helper that turns a beat
// width in bytes into the AXI AxSIZE encoding.
// ---------------------------------------------------------------------------
package axi_pkg;

   // Write-back port transaction phases
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } port_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AxSIZE is log2 of the number of bytes moved per beat
   function automatic logic [2:0] axi_size(input int unsigned bytes_per_beat);
      return 3'($clog2(bytes_per_beat));
   endfunction

endpackage

// File: rtl/w_beat_buffer.sv
// ---------------------------------------------------------------------------
// w_beat_buffer
// One-entry register slice between the line-data stream and the AXI W
// channel. Holds data, byte strobes and the last marker.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready     upstream handshake
//   in_data/in_strb/in_last upstream payload
//   out_valid / out_ready   downstream (AXI W) handshake
//   out_data/out_strb/out_last held payload
// ---------------------------------------------------------------------------
module w_beat_buffer #(
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_strb,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [DATA_W/8-1:0] out_strb,
   output logic                out_last
);

   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W/8-1:0] strb_q, strb_d;
   logic                last_q, last_d;

   // The slot can take a new beat when empty or when its current beat
   // leaves this very cycle, which gives back-to-back throughput.
   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_strb  = strb_q;
   assign out_last  = last_q;

   // Load on an upstream handshake; otherwise a downstream handshake empties
   // the slot. Payload only changes on a load, so it is stable while stalled.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      strb_d  = strb_q;
      last_d  = last_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
         strb_d  = in_strb;
         last_d  = in_last;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers; reset empties the slot and clears the payload
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/axi_burst_write_port.sv
// ---------------------------------------------------------------------------
// axi_burst_write_port
// Turns one dcache line-eviction request plus BEATS line-data beats into a
// single AXI4 INCR write burst, then waits for the B response before taking
// the next line.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready/req_addr line write request (any byte in the line)
//   data_valid/data_ready        line beat stream, lowest address first
//   data_bits/data_strb          beat payload
//   data_last                    pulses on the handshake of the final beat
//   aw_*                         AXI write address channel
//   w_*                          AXI write data channel
//   b_*                          AXI write response channel
//   done_valid/done_err          one-cycle completion pulse and error flag
//   busy                         transaction in progress
// ---------------------------------------------------------------------------
module axi_burst_write_port
   import axi_pkg::*;
#(
   parameter int              ADDR_W = 32,
   parameter int              DATA_W = 32,
   parameter int              BEATS  = 4,
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] WR_ID  = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                data_valid,
   output logic                data_ready,
   input  logic [DATA_W-1:0]   data_bits,
   input  logic [DATA_W/8-1:0] data_strb,
   output logic                data_last,
   output logic                aw_valid,
   input  logic                aw_ready,
   output logic [ADDR_W-1:0]   aw_addr,
   output logic [7:0]          aw_len,
   output logic [2:0]          aw_size,
   output logic [1:0]          aw_burst,
   output logic [ID_W-1:0]     aw_id,
   output logic                w_valid,
   input  logic                w_ready,
   output logic [DATA_W-1:0]   w_data,
   output logic [DATA_W/8-1:0] w_strb,
   output logic                w_last,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [1:0]          b_resp,
   input  logic [ID_W-1:0]     b_id,
   output logic                done_valid,
   output logic                done_err,
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(BEATS * STRB_W);
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam logic [ADDR_W-1:0] LINE_MASK =
      ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   port_state_e       state_q, state_d;
   logic              aw_pend_q, aw_pend_d;
   logic              w_pend_q, w_pend_d;
   logic [ADDR_W-1:0] line_addr_q, line_addr_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              done_valid_q, done_valid_d;
   logic              done_err_q, done_err_d;

   logic in_xfer;
   logic buf_in_ready;
   logic beats_left;
   logic beat_is_last;
   logic data_hs;
   logic aw_hs;
   logic w_hs;

   // Handshake qualifiers. Beats are refused once all BEATS have been taken,
   // so a final beat still parked in the slot cannot pull in an extra one.
   assign in_xfer      = (state_q == XFER);
   assign beats_left   = (beat_cnt_q != CNT_W'(BEATS));
   assign beat_is_last = (beat_cnt_q == CNT_W'(BEATS - 1));
   assign data_ready   = in_xfer && w_pend_q && beats_left && buf_in_ready;
   assign data_hs      = data_valid && data_ready;
   assign data_last    = data_hs && beat_is_last;

   assign aw_valid = in_xfer && aw_pend_q;
   assign aw_hs    = aw_valid && aw_ready;
   assign w_hs     = w_valid && w_ready;

   // AW fields read as zero when idle and are frozen while aw_valid is high
   assign aw_addr  = aw_valid ? line_addr_q : '0;
   assign aw_len   = aw_valid ? 8'(BEATS - 1) : 8'd0;
   assign aw_size  = aw_valid ? axi_size(STRB_W) : 3'd0;
   assign aw_burst = aw_valid ? AXI_BURST_INCR : 2'b00;
   assign aw_id    = aw_valid ? WR_ID : '0;

   assign req_ready  = (state_q == IDLE) && !reset;
   assign b_ready    = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign done_valid = done_valid_q;
   assign done_err   = done_err_q;

   w_beat_buffer #(
      .DATA_W (DATA_W)
   ) u_w_buf (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (data_hs),
      .in_ready  (buf_in_ready),
      .in_data   (data_bits),
      .in_strb   (data_strb),
      .in_last   (beat_is_last),
      .out_valid (w_valid),
      .out_ready (w_ready),
      .out_data  (w_data),
      .out_strb  (w_strb),
      .out_last  (w_last)
   );

   // Transaction sequencing. RESP is entered as soon as the AW and final W
   // handshakes have both happened (using the next-state pend flags), so
   // simultaneous AW/last-W handshakes reach RESP on the following cycle.
   // The last W handshake also means the slot is draining empty.
   always_comb begin
      state_d      = state_q;
      aw_pend_d    = aw_pend_q;
      w_pend_d     = w_pend_q;
      line_addr_d  = line_addr_q;
      beat_cnt_d   = beat_cnt_q;
      done_valid_d = 1'b0;
      done_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               line_addr_d = req_addr & LINE_MASK;
               beat_cnt_d  = '0;
               aw_pend_d   = 1'b1;
               w_pend_d    = 1'b1;
               state_d     = XFER;
            end
         end
         XFER: begin
            if (aw_hs) begin
               aw_pend_d = 1'b0;
            end
            if (data_hs) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            if (w_hs && w_last) begin
               w_pend_d = 1'b0;
            end
            if (!aw_pend_d && !w_pend_d) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (b_valid) begin
               done_valid_d = 1'b1;
               done_err_d   = (b_resp == RESP_SLVERR) || (b_resp == RESP_DECERR) ||
                              (b_id != WR_ID);
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; reset aborts any transaction in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         aw_pend_q    <= 1'b0;
         w_pend_q     <= 1'b0;
         line_addr_q  <= '0;
         beat_cnt_q   <= '0;
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         aw_pend_q    <= aw_pend_d;
         w_pend_q     <= w_pend_d;
         line_addr_q  <= line_addr_d;
         beat_cnt_q   <= beat_cnt_d;
         done_valid_q <= done_valid_d;
         done_err_q   <= done_err_d;
      end
   end

endmodule

// File: tb/tb_axi_burst_write_port.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_write_port
// Scoreboard bench for axi_burst_write_port: a 32-bit/4-beat instance driven
// through several AXI slave behaviours, plus a 128-bit/1-beat instance for
// the minimum transaction.
// ---------------------------------------------------------------------------
module tb_axi_burst_write_port;
   import axi_pkg::*;

   localparam int         BEATS = 4;
   localparam logic [3:0] WR_ID = 4'd3;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } beat_t;

   logic        clock, reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        data_valid, data_ready, data_last;
   logic [31:0] data_bits;
   logic [3:0]  data_strb;
   logic        aw_valid, aw_ready;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic [3:0]  aw_id;
   logic        w_valid, w_ready, w_last;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_valid, b_ready;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   logic        done_valid, done_err, busy;

   logic         p_req_valid, p_req_ready;
   logic [31:0]  p_req_addr;
   logic         p_data_valid, p_data_ready, p_data_last;
   logic [127:0] p_data_bits;
   logic [15:0]  p_data_strb;
   logic         p_aw_valid, p_aw_ready;
   logic [31:0]  p_aw_addr;
   logic [7:0]   p_aw_len;
   logic [2:0]   p_aw_size;
   logic [1:0]   p_aw_burst;
   logic [3:0]   p_aw_id;
   logic         p_w_valid, p_w_ready, p_w_last;
   logic [127:0] p_w_data;
   logic [15:0]  p_w_strb;
   logic         p_b_valid, p_b_ready;
   logic [1:0]   p_b_resp;
   logic [3:0]   p_b_id;
   logic         p_done_valid, p_done_err, p_busy;

   int checks = 0;
   int errors = 0;

   beat_t       beat_q[$];
   logic [31:0] aw_exp_q[$];
   logic        err_exp_q[$];

   int aw_hs_n, w_hs_n, last_n, done_n, b_hs_n;
   bit b_hs_last = 0;
   bit aw_block  = 0;
   int w_mode    = 0;
   int cyc       = 0;

   axi_burst_write_port #(
      .ADDR_W(32), .DATA_W(32), .BEATS(BEATS), .ID_W(4), .WR_ID(WR_ID)
   ) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .data_valid(data_valid), .data_ready(data_ready), .data_bits(data_bits),
      .data_strb(data_strb), .data_last(data_last),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
      .aw_size(aw_size), .aw_burst(aw_burst), .aw_id(aw_id),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
      .done_valid(done_valid), .done_err(done_err), .busy(busy)
   );

   axi_burst_write_port #(
      .ADDR_W(32), .DATA_W(128), .BEATS(1), .ID_W(4), .WR_ID(4'd0)
   ) u_dut_wide (
      .clock(clock), .reset(reset),
      .req_valid(p_req_valid), .req_ready(p_req_ready), .req_addr(p_req_addr),
      .data_valid(p_data_valid), .data_ready(p_data_ready), .data_bits(p_data_bits),
      .data_strb(p_data_strb), .data_last(p_data_last),
      .aw_valid(p_aw_valid), .aw_ready(p_aw_ready), .aw_addr(p_aw_addr),
      .aw_len(p_aw_len), .aw_size(p_aw_size), .aw_burst(p_aw_burst), .aw_id(p_aw_id),
      .w_valid(p_w_valid), .w_ready(p_w_ready), .w_data(p_w_data), .w_strb(p_w_strb),
      .w_last(p_w_last),
      .b_valid(p_b_valid), .b_ready(p_b_ready), .b_resp(p_b_resp), .b_id(p_b_id),
      .done_valid(p_done_valid), .done_err(p_done_err), .busy(p_busy)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case something never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // AXI slave ready behaviour: AW can be blocked, W is either always ready
   // or follows a repeating 1,0,0,1 pattern
   always @(posedge clock) begin
      #1;
      cyc++;
      aw_ready = !aw_block;
      if (w_mode == 0) w_ready = 1'b1;
      else             w_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
   end

   // Monitor at the falling edge: every value seen here is what the next
   // rising edge will act on. W payload is compared against the scoreboard
   // head every cycle it is valid, which also covers stability under stall.
   always @(negedge clock) begin
      if (!reset) begin
         if (aw_valid) begin
            if (aw_exp_q.size() == 0) begin
               checkOutput("aw_unexpected", aw_valid, 1'b0);
            end else begin
               checkOutput("aw_addr", aw_addr, aw_exp_q[0]);
               checkOutput("aw_len", aw_len, BEATS - 1);
               checkOutput("aw_size", aw_size, 2);
               checkOutput("aw_burst", aw_burst, AXI_BURST_INCR);
               checkOutput("aw_id", aw_id, WR_ID);
               if (aw_ready) begin
                  void'(aw_exp_q.pop_front());
                  aw_hs_n++;
               end
            end
         end
         if (w_valid) begin
            if (beat_q.size() == 0) begin
               checkOutput("w_unexpected", w_valid, 1'b0);
            end else begin
               checkOutput("w_data", w_data, beat_q[0].data);
               checkOutput("w_strb", w_strb, beat_q[0].strb);
               checkOutput("w_last", w_last, beat_q[0].last);
               if (w_ready) begin
                  void'(beat_q.pop_front());
                  w_hs_n++;
               end
            end
         end
         if (data_last) last_n++;
         if (b_valid && b_ready) b_hs_n++;
         if (done_valid) begin
            done_n++;
            checkOutput("done_after_b", b_hs_last, 1'b1);
            if (err_exp_q.size() == 0) checkOutput("done_unexpected", done_valid, 1'b0);
            else checkOutput("done_err", done_err, err_exp_q.pop_front());
         end
         b_hs_last = b_valid && b_ready;
      end
   end

   // Issue one line request and feed nbeats beats; expected AW and W beats
   // go onto the scoreboard as the DUT accepts them
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] seed,
                                input int nbeats, input bit stray);
      int guard;
      bit hs;
      aw_hs_n = 0; w_hs_n = 0; last_n = 0; done_n = 0; b_hs_n = 0;
      req_addr  = addr;
      req_valid = 1'b1;
      guard = 0; hs = 0;
      while (!hs && guard < 100) begin
         @(negedge clock); hs = req_ready;
         @(posedge clock); #1; guard++;
      end
      req_valid = 1'b0;
      if (!hs) begin
         checkOutput("req_timeout", 0, 1);
         return;
      end
      aw_exp_q.push_back(addr & 32'hFFFF_FFF0);
      checkOutput("aw_valid_rise", aw_valid, 1'b1);
      checkOutput("busy_xfer", busy, 1'b1);
      if (stray) begin
         b_valid = 1'b1; b_resp = RESP_SLVERR; b_id = WR_ID;
         repeat (3) begin
            @(negedge clock);
            checkOutput("stray_b_ready", b_ready, 1'b0);
         end
         @(posedge clock); #1;
         b_valid = 1'b0;
      end
      for (int i = 0; i < nbeats; i++) begin
         data_bits  = seed + 32'(i) * 32'h0101_0101;
         data_strb  = (i == 1) ? 4'h3 : (i == 2) ? 4'hC : 4'hF;
         data_valid = 1'b1;
         guard = 0; hs = 0;
         while (!hs && guard < 200) begin
            @(negedge clock); hs = data_ready;
            @(posedge clock); #1; guard++;
         end
         data_valid = 1'b0;
         if (!hs) begin
            checkOutput("beat_timeout", 0, 1);
            return;
         end
         beat_q.push_back(beat_t'{data: data_bits, strb: data_strb, last: (i == BEATS - 1)});
      end
   endtask

   // Answer with a B response once the port asks for it and check the
   // completion pulse plus the per-transaction handshake counts
   task automatic finishTransaction(input logic [1:0] resp, input logic [3:0] id,
                                    input logic exp_err);
      int guard = 0;
      while (!b_ready && guard < 200) begin
         @(posedge clock); #1; guard++;
      end
      if (!b_ready) begin
         checkOutput("bready_timeout", 0, 1);
         return;
      end
      b_resp = resp; b_id = id; b_valid = 1'b1;
      err_exp_q.push_back(exp_err);
      @(posedge clock); #1;
      b_valid = 1'b0;
      checkOutput("done_pulse", done_valid, 1'b1);
      checkOutput("req_ready_back", req_ready, 1'b1);
      @(posedge clock); #1;
      checkOutput("done_one_cycle", done_valid, 1'b0);
      checkOutput("aw_handshakes", aw_hs_n, 1);
      checkOutput("w_handshakes", w_hs_n, BEATS);
      checkOutput("data_last_pulses", last_n, 1);
      checkOutput("b_handshakes", b_hs_n, 1);
      checkOutput("done_count", done_n, 1);
      checkOutput("beats_drained", beat_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 0; req_addr = '0; data_valid = 0; data_bits = '0; data_strb = '0;
      aw_ready = 1; w_ready = 1; b_valid = 0; b_resp = '0; b_id = '0;
      p_req_valid = 0; p_req_addr = '0; p_data_valid = 0; p_data_bits = '0;
      p_data_strb = '0; p_aw_ready = 1; p_w_ready = 1; p_b_valid = 0;
      p_b_resp = '0; p_b_id = '0;

      #2;
      checkOutput("rst_req_ready", req_ready, 1'b0);
      checkOutput("rst_aw_valid", aw_valid, 1'b0);
      checkOutput("rst_aw_len", aw_len, 0);
      checkOutput("rst_w_valid", w_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      checkOutput("post_rst_req_ready", req_ready, 1'b1);
      checkOutput("post_rst_done", done_valid, 1'b0);
      checkOutput("post_rst_b_ready", b_ready, 1'b0);
      @(posedge clock); #1;

      $display("[TB] basic burst, all ready");
      applyStimulus(32'h1234_5678, 32'hA000_0000, BEATS, 0);
      finishTransaction(RESP_OKAY, WR_ID, 1'b0);

      $display("[TB] AW held off while W completes");
      aw_block = 1;
      applyStimulus(32'h0000_1024, 32'hB000_0010, BEATS, 0);
      repeat (10) begin
         @(posedge clock); #1;
         checkOutput("aw_wait_valid", aw_valid, 1'b1);
         checkOutput("aw_wait_no_bready", b_ready, 1'b0);
         checkOutput("aw_wait_no_done", done_valid, 1'b0);
      end
      aw_block = 0;
      finishTransaction(RESP_OKAY, WR_ID, 1'b0);

      $display("[TB] W ready toggling");
      w_mode = 1;
      applyStimulus(32'h8000_00F3, 32'hC0DE_0000, BEATS, 0);
      finishTransaction(RESP_OKAY, WR_ID, 1'b0);
      w_mode = 0;

      $display("[TB] SLVERR with stray B during XFER");
      applyStimulus(32'h4000_0040, 32'hD000_0000, BEATS, 1);
      finishTransaction(RESP_SLVERR, WR_ID, 1'b1);

      $display("[TB] wrong B id");
      applyStimulus(32'h4000_0080, 32'hE000_0000, BEATS, 0);
      finishTransaction(RESP_OKAY, WR_ID ^ 4'd1, 1'b1);

      $display("[TB] reset after second beat");
      applyStimulus(32'h5555_5550, 32'hF000_0000, 2, 0);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_aw_valid", aw_valid, 1'b0);
      checkOutput("abort_w_valid", w_valid, 1'b0);
      checkOutput("abort_w_data", w_data, 0);
      checkOutput("abort_data_ready", data_ready, 1'b0);
      checkOutput("abort_req_ready", req_ready, 1'b0);
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_b_ready", b_ready, 1'b0);
      beat_q.delete(); aw_exp_q.delete(); err_exp_q.delete();
      @(posedge clock); #3 reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("abort_idle_ready", req_ready, 1'b1);
      applyStimulus(32'h5555_5560, 32'h1111_0000, BEATS, 0);
      finishTransaction(RESP_OKAY, WR_ID, 1'b0);

      $display("[TB] 128-bit single-beat line");
      p_req_addr = 32'h0000_ABCD; p_req_valid = 1'b1;
      @(negedge clock);
      checkOutput("wide_req_ready", p_req_ready, 1'b1);
      @(posedge clock); #1;
      p_req_valid = 1'b0;
      checkOutput("wide_aw_valid", p_aw_valid, 1'b1);
      checkOutput("wide_aw_addr", p_aw_addr, 32'h0000_ABC0);
      checkOutput("wide_aw_len", p_aw_len, 0);
      checkOutput("wide_aw_size", p_aw_size, 4);
      checkOutput("wide_aw_burst", p_aw_burst, AXI_BURST_INCR);
      p_data_bits  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      p_data_strb  = 16'hF0F0;
      p_data_valid = 1'b1;
      @(negedge clock);
      checkOutput("wide_data_ready", p_data_ready, 1'b1);
      checkOutput("wide_data_last", p_data_last, 1'b1);
      @(posedge clock); #1;
      p_data_valid = 1'b0;
      checkOutput("wide_w_valid", p_w_valid, 1'b1);
      checkOutput("wide_w_data", p_w_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      checkOutput("wide_w_strb", p_w_strb, 16'hF0F0);
      checkOutput("wide_w_last", p_w_last, 1'b1);
      checkOutput("wide_aw_done", p_aw_valid, 1'b0);
      @(posedge clock); #1;
      checkOutput("wide_b_ready", p_b_ready, 1'b1);
      p_b_valid = 1'b1; p_b_resp = RESP_OKAY; p_b_id = 4'd0;
      @(posedge clock); #1;
      p_b_valid = 1'b0;
      checkOutput("wide_done", p_done_valid, 1'b1);
      checkOutput("wide_done_err", p_done_err, 1'b0);
      checkOutput("wide_req_ready_back", p_req_ready, 1'b1);
      @(posedge clock); #1;
      checkOutput("wide_done_pulse", p_done_valid, 1'b0);

      repeat (2) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
